pipeline_hazard_ctrl: RTL and testbench

Parametrised combined hazard-detection and forwarding controller for the 5-stage MIPS pipeline. It replaces the separate always-idle Hazard unit and fixed two-source Forward unit. It keeps its own shadow pipeline of destination-register entries for EXE, MEM, WB and older stages. From these it drives per-operand forwarding selects for EXE, load-use stalls/bubbles, multi-cycle data-memory wait stalls, optional branch flush, and the STALL/FLUSH pair for every pipeline register.

---
 rtl/pipeline_hazard_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Combined hazard detection and forwarding controller for the 5-stage pipeline.
// A shadow copy of each in-flight instruction's destination is kept for EXE and
// the stages behind it. Forwarding selects, load-use bubbles, data-memory wait
// stalls and the branch flush are all derived from that copy.
module pipeline_hazard_ctrl #(
  parameter int unsigned NUM_SRC         = 2,
  parameter int unsigned NUM_FWD_STAGES  = 2,
  parameter int unsigned LOAD_USE_STALLS = 1,
  parameter int unsigned DELAY_SLOT      = 1,
  parameter int unsigned REG_W           = 5
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     IDValid_IN,
  input  logic [NUM_SRC*REG_W-1:0] IDSrcReg_IN,
  input  logic [NUM_SRC-1:0]       IDSrcUse_IN,
  input  logic [REG_W-1:0]         IDDestReg_IN,
  input  logic                     IDWriteEnable_IN,
  input  logic                     IDIsLoad_IN,
  input  logic                     BranchTaken_IN,
  input  logic                     MemReq_IN,
  input  logic                     MemReady_IN,
  output logic [NUM_SRC*2-1:0]     FwdSel_OUT,
  output logic                     STALL_IFID,
  output logic                     FLUSH_IFID,
  output logic                     STALL_IDEXE,
  output logic                     FLUSH_IDEXE,
  output logic                     STALL_EXEMEM,
  output logic                     FLUSH_EXEMEM,
  output logic                     STALL_MEMWB,
  output logic                     FLUSH_MEMWB,
  output logic [15:0]              StallCount_OUT
);

  localparam int unsigned Depth = NUM_FWD_STAGES + 1;

  typedef enum logic [1:0] {StRun, StLuStall, StMemWait} state_e;

  state_e             state_q, state_d;
  logic [1:0]         lu_cnt_q, lu_cnt_d;
  logic [15:0]        stall_cnt_q;

  // Slot 0 is EXE, slot k is k stages past EXE.
  logic [Depth-1:0]   sh_valid_q;
  logic [Depth-1:0]   sh_we_q;
  logic [REG_W-1:0]   sh_dest_q [Depth];
  // Only the EXE entry's load flag is ever consulted, so older slots drop it.
  logic               sh_load_q;
  logic [REG_W-1:0]   exe_src_q [NUM_SRC];
  logic [NUM_SRC-1:0] exe_use_q;

  logic [Depth-1:0]     live;
  logic [NUM_SRC*2-1:0] fwd_sel;
  logic                 src_match;
  logic                 lu_hazard;
  logic                 mem_stall;
  logic                 lu_stall;

  // Slot k can supply a result: valid, writes a register, and not $0.
  always_comb begin
    live = '0;
    for (int k = 0; k < Depth; k++) begin
      live[k] = sh_valid_q[k] && sh_we_q[k] && (sh_dest_q[k] != '0);
    end
  end

  // Forwarding select: scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_sel = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
        if (exe_use_q[s] && live[k] && (sh_dest_q[k] == exe_src_q[s])) begin
          fwd_sel[s*2 +: 2] = 2'(k);
        end
      end
    end
  end

  // Load-use hazard: ID reads the register a load in EXE is about to produce.
  always_comb begin
    src_match = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (IDSrcUse_IN[s] && (IDSrcReg_IN[s*REG_W +: REG_W] == sh_dest_q[0])) begin
        src_match = 1'b1;
      end
    end
  end

  assign lu_hazard = IDValid_IN && src_match && live[0] && sh_load_q;

  // Stall FSM next state. The cycle memory becomes ready already behaves as the
  // state being resumed, so a pending load-use stall continues without a gap.
  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    lu_stall = 1'b0;
    mem_stall = (state_q == StMemWait) ? !MemReady_IN : (MemReq_IN && !MemReady_IN);
    if (mem_stall) begin
      state_d = StMemWait;
    end else if (lu_cnt_q != 2'd0) begin
      lu_stall = 1'b1;
      lu_cnt_d = lu_cnt_q - 2'd1;
      state_d  = (lu_cnt_q == 2'd1) ? StRun : StLuStall;
    end else if (lu_hazard) begin
      lu_stall = 1'b1;
      if (LOAD_USE_STALLS > 1) begin
        lu_cnt_d = 2'(LOAD_USE_STALLS - 1);
        state_d  = StLuStall;
      end else begin
        state_d = StRun;
      end
    end else begin
      state_d = StRun;
    end
  end

  // Pipeline register controls, priority memory wait > load-use > branch.
  always_comb begin
    FwdSel_OUT   = '0;
    STALL_IFID   = 1'b0;
    FLUSH_IFID   = 1'b0;
    STALL_IDEXE  = 1'b0;
    FLUSH_IDEXE  = 1'b0;
    STALL_EXEMEM = 1'b0;
    FLUSH_EXEMEM = 1'b0;
    STALL_MEMWB  = 1'b0;
    FLUSH_MEMWB  = 1'b0;
    if (!RESET) begin
      FwdSel_OUT = fwd_sel;
      if (mem_stall) begin
        STALL_IFID   = 1'b1;
        STALL_IDEXE  = 1'b1;
        STALL_EXEMEM = 1'b1;
        FLUSH_MEMWB  = 1'b1;
      end else if (lu_stall) begin
        STALL_IFID  = 1'b1;
        FLUSH_IDEXE = 1'b1;
      end else if (BranchTaken_IN && (DELAY_SLOT == 0)) begin
        FLUSH_IFID = 1'b1;
      end
    end
  end

  // FSM state, load-use counter and saturating stall counter.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StRun;
      lu_cnt_q    <= 2'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      if (STALL_IFID && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign StallCount_OUT = stall_cnt_q;

  // Shadow pipeline: hold on memory wait, bubble into EXE on load-use, else advance.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sh_valid_q <= '0;
      sh_we_q    <= '0;
      sh_load_q  <= 1'b0;
      exe_use_q  <= '0;
      for (int k = 0; k < Depth; k++) begin
        sh_dest_q[k] <= '0;
      end
      for (int s = 0; s < NUM_SRC; s++) begin
        exe_src_q[s] <= '0;
      end
    end else if (!mem_stall) begin
      for (int k = Depth - 1; k >= 1; k--) begin
        sh_valid_q[k] <= sh_valid_q[k-1];
        sh_we_q[k]    <= sh_we_q[k-1];
        sh_dest_q[k]  <= sh_dest_q[k-1];
      end
      if (lu_stall) begin
        sh_valid_q[0] <= 1'b0;
        exe_use_q     <= '0;
      end else begin
        sh_valid_q[0] <= IDValid_IN;
        sh_we_q[0]    <= IDWriteEnable_IN;
        sh_dest_q[0]  <= IDDestReg_IN;
        sh_load_q     <= IDIsLoad_IN;
        exe_use_q     <= IDSrcUse_IN & {NUM_SRC{IDValid_IN}};
        for (int s = 0; s < NUM_SRC; s++) begin
          exe_src_q[s] <= IDSrcReg_IN[s*REG_W +: REG_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two configurations driven by one stimulus
// stream, each compared every cycle against an instruction-level reference.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        idv = 1'b0;
  logic [9:0]  src = '0;
  logic [1:0]  src_use = '0;
  logic [4:0]  dst = '0;
  logic        we = 1'b0;
  logic        ld = 1'b0;
  logic        br = 1'b0;
  logic        req = 1'b0;
  logic        rdy = 1'b1;

  wire [3:0]  fwd_a, fwd_b;
  wire [7:0]  ctl_a, ctl_b;
  wire [15:0] cnt_a, cnt_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Config A: two forwarding stages, one load-use stall, branch flush enabled.
  pipeline_hazard_ctrl #(
    .NUM_SRC(2), .NUM_FWD_STAGES(2), .LOAD_USE_STALLS(1), .DELAY_SLOT(0), .REG_W(5)
  ) dut_a (
    .CLOCK(clk), .RESET(rst), .IDValid_IN(idv), .IDSrcReg_IN(src), .IDSrcUse_IN(src_use),
    .IDDestReg_IN(dst), .IDWriteEnable_IN(we), .IDIsLoad_IN(ld), .BranchTaken_IN(br),
    .MemReq_IN(req), .MemReady_IN(rdy), .FwdSel_OUT(fwd_a),
    .STALL_IFID(ctl_a[7]), .FLUSH_IFID(ctl_a[6]), .STALL_IDEXE(ctl_a[5]),
    .FLUSH_IDEXE(ctl_a[4]), .STALL_EXEMEM(ctl_a[3]), .FLUSH_EXEMEM(ctl_a[2]),
    .STALL_MEMWB(ctl_a[1]), .FLUSH_MEMWB(ctl_a[0]), .StallCount_OUT(cnt_a)
  );

  // Config B: three forwarding stages, two load-use stalls, delay slot.
  pipeline_hazard_ctrl #(
    .NUM_SRC(2), .NUM_FWD_STAGES(3), .LOAD_USE_STALLS(2), .DELAY_SLOT(1), .REG_W(5)
  ) dut_b (
    .CLOCK(clk), .RESET(rst), .IDValid_IN(idv), .IDSrcReg_IN(src), .IDSrcUse_IN(src_use),
    .IDDestReg_IN(dst), .IDWriteEnable_IN(we), .IDIsLoad_IN(ld), .BranchTaken_IN(br),
    .MemReq_IN(req), .MemReady_IN(rdy), .FwdSel_OUT(fwd_b),
    .STALL_IFID(ctl_b[7]), .FLUSH_IFID(ctl_b[6]), .STALL_IDEXE(ctl_b[5]),
    .FLUSH_IDEXE(ctl_b[4]), .STALL_EXEMEM(ctl_b[3]), .FLUSH_EXEMEM(ctl_b[2]),
    .STALL_MEMWB(ctl_b[1]), .FLUSH_MEMWB(ctl_b[0]), .StallCount_OUT(cnt_b)
  );

  // Reference: per config, the instructions in flight at EXE and beyond.
  typedef struct {
    bit       v;
    bit [4:0] dest;
    bit       we;
    bit       ld;
  } rec_t;

  int nf_of  [2] = '{2, 3};
  int lus_of [2] = '{1, 2};
  int ds_of  [2] = '{0, 1};

  rec_t     hist [2][4];
  bit [4:0] xsrc [2][2];
  bit       xuse [2][2];
  int       lu_left [2];
  bit       waiting [2];
  int       scnt [2];

  // Planned action at the coming edge: 0 advance, 1 bubble into EXE, 2 freeze.
  int         plan [2];
  int         plan_lu [2];
  bit         plan_wait [2];
  logic [7:0] exp_ctl [2];
  logic [3:0] exp_fwd [2];
  logic [15:0] exp_cnt [2];

  localparam logic [7:0] CtlMem    = 8'hA9;
  localparam logic [7:0] CtlLu     = 8'h90;
  localparam logic [7:0] CtlBranch = 8'h40;

  function automatic bit live(int d, int k);
    return hist[d][k].v && hist[d][k].we && (hist[d][k].dest != 5'd0);
  endfunction

  // Youngest instruction past EXE that will write register r, or 0.
  function automatic int producer(int d, bit [4:0] r);
    for (int k = 1; k <= nf_of[d]; k++) begin
      if (live(d, k) && hist[d][k].dest == r) return k;
    end
    return 0;
  endfunction

  task automatic model_reset(int d);
    for (int k = 0; k < 4; k++) hist[d][k] = '{v: 1'b0, dest: 5'd0, we: 1'b0, ld: 1'b0};
    for (int s = 0; s < 2; s++) begin
      xsrc[d][s] = 5'd0;
      xuse[d][s] = 1'b0;
    end
    lu_left[d] = 0;
    waiting[d] = 1'b0;
    scnt[d]    = 0;
  endtask

  task automatic predict();
    for (int d = 0; d < 2; d++) begin
      bit mem;
      bit haz;
      if (rst) model_reset(d);
      exp_fwd[d] = '0;
      for (int s = 0; s < 2; s++) begin
        if (xuse[d][s]) exp_fwd[d][s*2 +: 2] = 2'(producer(d, xsrc[d][s]));
      end
      haz = 1'b0;
      if (idv && live(d, 0) && hist[d][0].ld) begin
        for (int s = 0; s < 2; s++) begin
          if (src_use[s] && src[s*5 +: 5] == hist[d][0].dest) haz = 1'b1;
        end
      end
      mem = waiting[d] ? !rdy : (req && !rdy);
      plan_lu[d]   = lu_left[d];
      plan_wait[d] = 1'b0;
      if (rst) begin
        exp_ctl[d] = '0;
        exp_fwd[d] = '0;
        plan[d]    = 2;
      end else if (mem) begin
        exp_ctl[d]   = CtlMem;
        plan[d]      = 2;
        plan_wait[d] = 1'b1;
      end else if (lu_left[d] > 0) begin
        exp_ctl[d] = CtlLu;
        plan[d]    = 1;
        plan_lu[d] = lu_left[d] - 1;
      end else if (haz) begin
        exp_ctl[d] = CtlLu;
        plan[d]    = 1;
        plan_lu[d] = lus_of[d] - 1;
      end else begin
        exp_ctl[d] = (br && ds_of[d] == 0) ? CtlBranch : 8'h00;
        plan[d]    = 0;
      end
      exp_cnt[d] = 16'(scnt[d]);
    end
  endtask

  task automatic commit();
    for (int d = 0; d < 2; d++) begin
      if (exp_ctl[d][7] && scnt[d] < 65535) scnt[d]++;
      waiting[d] = plan_wait[d];
      lu_left[d] = plan_lu[d];
      if (plan[d] != 2) begin
        for (int k = nf_of[d]; k >= 1; k--) hist[d][k] = hist[d][k-1];
        if (plan[d] == 1) begin
          hist[d][0] = '{v: 1'b0, dest: 5'd0, we: 1'b0, ld: 1'b0};
          xuse[d][0] = 1'b0;
          xuse[d][1] = 1'b0;
        end else begin
          hist[d][0] = '{v: idv, dest: dst, we: we, ld: ld};
          for (int s = 0; s < 2; s++) begin
            xsrc[d][s] = src[s*5 +: 5];
            xuse[d][s] = src_use[s] && idv;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #2;
    predict();
    chk("fwd_a", 16'(fwd_a), 16'(exp_fwd[0]));
    chk("ctl_a", 16'(ctl_a), 16'(exp_ctl[0]));
    chk("cnt_a", cnt_a, exp_cnt[0]);
    chk("fwd_b", 16'(fwd_b), 16'(exp_fwd[1]));
    chk("ctl_b", 16'(ctl_b), 16'(exp_ctl[1]));
    chk("cnt_b", cnt_b, exp_cnt[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic id(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit us,
                    input bit ut, input bit [4:0] rd, input bit w, input bit l);
    idv = v; src = {rt, rs}; src_use = {ut, us}; dst = rd; we = w; ld = l;
  endtask

  task automatic nop();
    id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic rand_inputs();
    id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
       $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
       $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0);
    br  = ($urandom_range(0, 5) == 0);
    req = ($urandom_range(0, 2) == 0);
    rdy = ($urandom_range(0, 2) != 0);
  endtask

  int sc0;

  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      settle();
      chk("rst_hold_ctl_a", 16'(ctl_a), 16'h0);
      chk("rst_hold_fwd_b", 16'(fwd_b), 16'h0);
      tick();
    end
    rst = 1'b0; nop(); br = 1'b0; req = 1'b0; rdy = 1'b1;
    settle(); chk("post_rst_cnt_a", cnt_a, 16'h0); tick();

    // add $3,$1,$2 ; sub $4,$3,$5 ; or $6,$3,$4
    id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); step();
    id(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0); step();
    id(1, 5'd3, 5'd4, 1, 1, 5'd6, 1, 0);
    settle(); chk("sub_rs_fwd_a", 16'(fwd_a[1:0]), 16'd1); chk("sub_nostall_a", 16'(ctl_a), 0);
    tick();
    nop();
    settle(); chk("or_fwd_a", 16'(fwd_a), 16'h6); chk("or_fwd_b", 16'(fwd_b), 16'h6); tick();

    // Writes to $0 never forward.
    id(1, 5'd1, 5'd1, 1, 1, 5'd0, 1, 0); step();
    id(1, 5'd0, 5'd0, 1, 1, 5'd9, 1, 0); step();
    nop(); settle(); chk("zero_fwd_a", 16'(fwd_a), 16'h0); tick();

    // Two writers of $7 in flight: the youngest wins; unused rt never forwards.
    id(1, 5'd1, 5'd1, 1, 1, 5'd7, 1, 0); step();
    id(1, 5'd2, 5'd2, 1, 1, 5'd7, 1, 0); step();
    id(1, 5'd7, 5'd7, 1, 0, 5'd10, 1, 0); step();
    nop(); settle();
    chk("youngest_fwd_a", 16'(fwd_a[1:0]), 16'd1); chk("unused_rt_fwd_a", 16'(fwd_a[3:2]), 0);
    tick();

    // lw $8 ; add $9,$8,$8
    id(1, 5'd1, 5'd1, 1, 1, 5'd8, 1, 1); step();
    id(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0);
    settle(); chk("lu_ctl_a", 16'(ctl_a), 16'(CtlLu)); chk("lu_ctl_b", 16'(ctl_b), 16'(CtlLu));
    tick();
    settle(); chk("lu_done_a", 16'(ctl_a), 0); chk("lu2_ctl_b", 16'(ctl_b), 16'(CtlLu)); tick();
    settle(); chk("lu_fwd_a", 16'(fwd_a), 16'hA); chk("lu_done_b", 16'(ctl_b), 0); tick();
    nop(); settle(); chk("lu_fwd_b", 16'(fwd_b), 16'hF); tick();

    // Memory wait of three cycles.
    req = 1'b1; rdy = 1'b0; sc0 = scnt[0];
    for (int i = 0; i < 3; i++) begin
      settle(); chk("mw_ctl_a", 16'(ctl_a), 16'(CtlMem)); tick();
    end
    rdy = 1'b1;
    settle(); chk("mw_cnt_a", cnt_a, 16'(sc0 + 3)); chk("mw_release_a", 16'(ctl_a), 0); tick();
    req = 1'b0;

    // Memory wait arriving in the middle of config B's two-cycle load-use stall.
    id(1, 5'd1, 5'd1, 1, 1, 5'd10, 1, 1); step();
    id(1, 5'd10, 5'd2, 1, 1, 5'd11, 1, 0);
    settle(); chk("lu_start_b", 16'(ctl_b), 16'(CtlLu)); tick();
    req = 1'b1; rdy = 1'b0;
    settle(); chk("mw_in_lu_b", 16'(ctl_b), 16'(CtlMem)); tick();
    step();
    rdy = 1'b1;
    settle(); chk("lu_resume_b", 16'(ctl_b), 16'(CtlLu)); tick();
    req = 1'b0;
    settle(); chk("lu_after_b", 16'(ctl_b), 0); tick();

    // Taken branch: one-cycle flush only without a delay slot.
    nop(); br = 1'b1;
    settle(); chk("br_flush_a", 16'(ctl_a), 16'(CtlBranch)); chk("br_noflush_b", 16'(ctl_b), 0);
    tick();
    br = 1'b0; settle(); chk("br_once_a", 16'(ctl_a), 0); tick();
    id(1, 5'd1, 5'd1, 1, 1, 5'd12, 1, 1); step();
    id(1, 5'd12, 5'd3, 1, 1, 5'd13, 1, 0); br = 1'b1;
    settle(); chk("br_in_lu_a", 16'(ctl_a), 16'(CtlLu)); tick();
    br = 1'b0; nop(); step(); step();

    // Reset asserted in the middle of a memory wait.
    req = 1'b1; rdy = 1'b0; step();
    settle(); chk("mw_again_a", 16'(ctl_a), 16'(CtlMem)); tick();
    rst = 1'b1;
    settle();
    chk("rst_mid_ctl_a", 16'(ctl_a), 0); chk("rst_mid_ctl_b", 16'(ctl_b), 0);
    chk("rst_mid_cnt_a", cnt_a, 0);
    tick();
    rst = 1'b0; req = 1'b0; rdy = 1'b1; step();

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 127) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
